// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants, control-bit bundle and sync polarity helper.
// Default timing is 640x480@60 (800x525 totals). Sync pulses are active-low.
package vga_timing_pkg;

    localparam int CNT_W        = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Level driven on hs/vs while the sync pulse is asserted.
    localparam logic SYNC_ACTIVE = 1'b0;

    // Control bits that travel alongside the pixel pipeline.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_ctrl_t;

    // Idle control word: both syncs deasserted, no data enable.
    localparam vga_ctrl_t CTRL_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, de: 1'b0};

    // Map "inside sync pulse" to the pin level.
    function automatic logic sync_level(input logic in_pulse);
        return in_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parameterised shift register with synchronous reset to RESET_VAL.
// DEPTH = 0 collapses to a plain wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift one stage per clock; reset flushes every stage to the idle value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= RESET_VAL;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_out.sv
// VGA raster generator and output stage.
// Emits pixel coordinates upstream, receives RGB PIX_LAT cycles later, delays
// hs/vs/de by the same amount and registers everything at the pins
// (coordinate-to-pin latency PIX_LAT+1). Colour is forced to black when de=0.
// Optional build macro VGA_TEST_PATTERN_EN adds input test_en, which replaces
// the mux colour with eight vertical colour bars indexed by delayed hcnt[9:7].
module vga_scan_out
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIX_LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_active,
    output logic             frame_start,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_en,
`endif
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    vga_ctrl_t        ctrl_raw;
    vga_ctrl_t        ctrl_dly;
    logic [7:0]       sel_r;
    logic [7:0]       sel_g;
    logic [7:0]       sel_b;

    // Raster counters: hcnt wraps every line, vcnt steps only on the hcnt wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= CNT_ZERO;
            vcnt <= CNT_ZERO;
        end else if (hcnt == H_LAST) begin
            hcnt <= CNT_ZERO;
            if (vcnt == V_LAST) begin
                vcnt <= CNT_ZERO;
            end else begin
                vcnt <= vcnt + CNT_ONE;
            end
        end else begin
            hcnt <= hcnt + CNT_ONE;
        end
    end

    assign pix_x = hcnt;
    assign pix_y = vcnt;

    // Decode coordinate-side status and the undelayed sync/enable bits.
    always_comb begin
        pix_active  = (hcnt < H_ACT) && (vcnt < V_ACT);
        frame_start = (hcnt == CNT_ZERO) && (vcnt == CNT_ZERO);
        ctrl_raw.hs = sync_level((hcnt >= HS_START) && (hcnt < HS_END));
        ctrl_raw.vs = sync_level((vcnt >= VS_START) && (vcnt < VS_END));
        ctrl_raw.de = pix_active;
    end

    // Match control timing to the upstream colour latency.
    vga_delay_line #(
        .WIDTH    ($bits(vga_ctrl_t)),
        .DEPTH    (PIX_LAT),
        .RESET_VAL(CTRL_IDLE)
    ) u_ctrl_dly (
        .clk(clk),
        .rst(rst),
        .d  (ctrl_raw),
        .q  (ctrl_dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;

    // Bar index rides the same delay as hs/vs/de so bars line up with de.
    vga_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIX_LAT),
        .RESET_VAL(3'b000)
    ) u_bar_dly (
        .clk(clk),
        .rst(rst),
        .d  (hcnt[9:7]),
        .q  (bar_idx)
    );

    // Pick test bars or mux colour for the output register.
    always_comb begin
        sel_r = red;
        sel_g = green;
        sel_b = blue;
        if (test_en) begin
            sel_r = bar_idx[2] ? 8'hFF : 8'h00;
            sel_g = bar_idx[1] ? 8'hFF : 8'h00;
            sel_b = bar_idx[0] ? 8'hFF : 8'h00;
        end else begin
            sel_r = red;
            sel_g = green;
            sel_b = blue;
        end
    end
`else
    // Output register always reflects the mux colour.
    always_comb begin
        sel_r = red;
        sel_g = green;
        sel_b = blue;
    end
`endif

    // Pin register: captures delayed control with colour, black outside active video.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hs <= ~SYNC_ACTIVE;
            vga_vs <= ~SYNC_ACTIVE;
            vga_de <= 1'b0;
            vga_r  <= 8'h00;
            vga_g  <= 8'h00;
            vga_b  <= 8'h00;
        end else begin
            vga_hs <= ctrl_dly.hs;
            vga_vs <= ctrl_dly.vs;
            vga_de <= ctrl_dly.de;
            if (ctrl_dly.de) begin
                vga_r <= sel_r;
                vga_g <= sel_g;
                vga_b <= sel_b;
            end else begin
                vga_r <= 8'h00;
                vga_g <= 8'h00;
                vga_b <= 8'h00;
            end
        end
    end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Display back end downstream of the layer-select RGB mux.
- Generates 640x480@60 raster timing and emits pixel coordinates to the upstream layer generators.
- Accepts the mux's 8-bit red/green/blue a fixed number of cycles later, aligns sync and blank to that latency, and drives registered VGA outputs.
- Forces black outside the active area.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back porch
- PIX_LAT, 2, cycles from pix_x/pix_y to matching red/green/blue at the input; 0 to 8 legal

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pix_x  out  10  current horizontal count (hcnt)
- pix_y  out  10  current vertical count (vcnt)
- pix_active  out  1  hcnt<H_ACTIVE and vcnt<V_ACTIVE
- frame_start  out  1  one-cycle pulse when hcnt=0 and vcnt=0
- red  in  8  pixel red from mux, valid PIX_LAT cycles after its coordinate
- green  in  8  pixel green from mux
- blue  in  8  pixel blue from mux
- vga_r  out  8  registered red
- vga_g  out  8  registered green
- vga_b  out  8  registered blue
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_de  out  1  data enable, aligned with vga_r/g/b

Behaviour:
- Totals: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525.
- hcnt counts 0..H_TOTAL-1 and wraps to 0.
- vcnt increments only on the cycle hcnt wraps, and wraps to 0 after V_TOTAL-1 in the same cycle as hcnt wraps.
- pix_x/pix_y are hcnt/vcnt directly, from registers. pix_active and frame_start decode combinationally from those registers.
- Raw hsync is low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- Raw vsync is low for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Alignment:
  - Raw hs/vs/active pass through a PIX_LAT-deep shift register (direct wire when PIX_LAT=0).
  - The output register then captures the delayed hs/vs/de together with red/green/blue.
  - Total latency, coordinate to pin: PIX_LAT+1 cycles for all of vga_hs/vs/de/r/g/b.
- Blanking: when delayed de=0, vga_r/g/b are loaded with 0 regardless of input values.
- Reset state:
  - hcnt=vcnt=0.
  - Every delay stage holds inactive values: hs=1, vs=1, de=0.
  - vga_hs=vga_vs=1, vga_de=0, vga_r/g/b=0.
- After reset:
  - The first cycle after rst deasserts presents pix_x=0, pix_y=0, frame_start=1.
  - Reset asserted mid-frame aborts the frame; no partial sync pulse survives. The delay line flushes to inactive on the same edge.
- Input colour is never latched outside the output register.

Optional Feature:
- VGA_TEST_PATTERN_EN:
  - When defined, adds input test_en (1 bit).
  - With test_en=1, the output register loads 8 vertical colour bars instead of red/green/blue. Bar index = delayed hcnt[9:7] (hcnt carried through the same delay line).
  - Bar colour = {index[2]?FF:00, index[1]?FF:00, index[0]?FF:00}.
  - Blanking still forces 0.
- When undefined, the port and the extra delay bits are absent, and the output always reflects the mux inputs.

Decomposition:
- Package vga_timing_pkg:
  - Default porch/sync/active constants, derived H_TOTAL/V_TOTAL, counter width constant (10).
  - Sync polarity constant (active-low).
- One sub-module, vga_delay_line: parameterised WIDTH and DEPTH shift register with synchronous reset to a RESET_VAL parameter; DEPTH=0 is a pass-through.
- Used for hs/vs/de and, under the macro, hcnt[9:7].

Test Plan:
- Reset state: hold rst 5 cycles.
  - During reset: vga_hs=vga_vs=1, vga_de=0, vga_r/g/b=0.
  - First cycle after release: pix_x=0, pix_y=0, frame_start=1.
- Line timing, default params:
  - vga_hs first falls 656+3 cycles after reset release, stays low 96 cycles, and repeats every 800 cycles.
  - vga_de is high 640 of every 800 cycles on lines 0..479.
- Frame timing:
  - frame_start pulses every 420000 cycles.
  - vga_vs is low for exactly 1600 cycles beginning at line 490.
- Alignment: model drives red=pix_x[7:0] delayed 2 cycles, green=pix_y[7:0] likewise.
  - While vga_de=1, vga_r equals x mod 256 for that pixel, including x=0 and x=639.
- Blanking: hold red/green/blue=FF constantly.
  - vga_r/g/b=FF exactly when vga_de=1, and 00 otherwise.
- Mid-frame reset: assert rst at line 300, x=100, for 1 cycle.
  - Next cycle outputs are inactive/zero.
  - Counting restarts at 0,0 with frame_start=1, and the next vga_hs fall is 659 cycles later.
- Under VGA_TEST_PATTERN_EN with test_en=1: pixel x=200 (bar 1) outputs 00/00/FF, and pixel x=639 (bar 4) outputs FF/00/00.
